booth_divider: RTL and testbench

- Sequential signed radix-2 restoring divider: the inverse companion to the team's sequential Booth multiplier.
- Accepts two's-complement dividend/divisor on a start pulse, iterates one quotient bit per clock, and returns quotient, remainder and status with a one-cycle done pulse.
- Used by datapath blocks needing division back-to-back with the multiplier, e.g. for multiply/divide round-trip checks.

---
 rtl/booth_divider.sv | 130 +++++++++++++
 tb/tb_booth_divider.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/booth_divider.sv
// Sequential signed radix-2 restoring divider.
// One quotient bit per clock on operand magnitudes, signs applied in a final
// fix-up cycle. Divide-by-zero and most-negative/-1 overflow are flagged and
// produce fixed results after the same latency as a normal divide.
module booth_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             dbz,
    output logic             ovf
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvd_q;      // original dividend (sign + dbz remainder)
    logic             sgn_d_q;    // divisor sign
    logic [WIDTH-1:0] dvs_mag_q;  // |divisor|; most-negative fits as unsigned
    logic [WIDTH-1:0] prem_q;     // partial remainder, always < |divisor|
    logic [WIDTH-1:0] qmag_q;     // dividend bits shifting out, quotient bits in
    logic             dbz_pend_q;
    logic             ovf_pend_q;
    logic             busy_q, done_q, dbz_q, ovf_q;
    logic [WIDTH-1:0] quo_q, rem_q;

    logic [WIDTH-1:0] dvd_mag_d, dvs_mag_d;
    logic [WIDTH:0]   rem_sh_d;
    logic             ge_d;
    logic [WIDTH-1:0] prem_d, qmag_d;
    logic [WIDTH-1:0] quo_fix_d, rem_fix_d;

    // Operand magnitudes, one restoring step, and the signed fix-up values
    always_comb begin
        dvd_mag_d = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
        dvs_mag_d = divisor[WIDTH-1]  ? (~divisor  + WIDTH'(1)) : divisor;

        // Shift the next dividend bit into the partial remainder; the extra
        // top bit keeps the compare exact before subtracting.
        rem_sh_d = {prem_q, qmag_q[WIDTH-1]};
        ge_d     = (rem_sh_d >= {1'b0, dvs_mag_q});
        prem_d   = ge_d ? (rem_sh_d[WIDTH-1:0] - dvs_mag_q) : rem_sh_d[WIDTH-1:0];
        qmag_d   = {qmag_q[WIDTH-2:0], ge_d};

        quo_fix_d = (dvd_q[WIDTH-1] ^ sgn_d_q) ? (~qmag_q + WIDTH'(1)) : qmag_q;
        rem_fix_d = dvd_q[WIDTH-1] ? (~prem_q + WIDTH'(1)) : prem_q;
        if (dbz_pend_q) begin
            quo_fix_d = ALL_ONES;
            rem_fix_d = dvd_q;
        end else if (ovf_pend_q) begin
            quo_fix_d = MOST_NEG;
            rem_fix_d = '0;
        end
    end

    // Control FSM with registered results and status
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dvd_q      <= '0;
            sgn_d_q    <= 1'b0;
            dvs_mag_q  <= '0;
            prem_q     <= '0;
            qmag_q     <= '0;
            dbz_pend_q <= 1'b0;
            ovf_pend_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            quo_q      <= '0;
            rem_q      <= '0;
            dbz_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        dvd_q      <= dividend;
                        sgn_d_q    <= divisor[WIDTH-1];
                        dvs_mag_q  <= dvs_mag_d;
                        qmag_q     <= dvd_mag_d;
                        prem_q     <= '0;
                        cnt_q      <= '0;
                        dbz_pend_q <= (divisor == '0);
                        ovf_pend_q <= (dividend == MOST_NEG) && (divisor == ALL_ONES);
                        busy_q     <= 1'b1;
                        state_q    <= CALC;
                    end
                end
                CALC: begin
                    prem_q <= prem_d;
                    qmag_q <= qmag_d;
                    cnt_q  <= cnt_q + CW'(1);
                    if (cnt_q == CW'(WIDTH-1)) state_q <= FIX;
                end
                FIX: begin
                    quo_q   <= quo_fix_d;
                    rem_q   <= rem_fix_d;
                    dbz_q   <= dbz_pend_q;
                    ovf_q   <= ovf_pend_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign quotient  = quo_q;
    assign remainder = rem_q;
    assign dbz       = dbz_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_booth_divider.sv
// Bench for booth_divider: directed cases, random ops and a full operand sweep
// checked against an integer-arithmetic reference model.
module tb_booth_divider;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] dividend = '0;
    logic [W-1:0] divisor = '0;
    logic         busy, done, dbz, ovf;
    logic [W-1:0] quotient, remainder;

    int n_run  = 0;
    int n_fail = 0;

    booth_divider #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .dividend(dividend), .divisor(divisor),
        .busy(busy), .done(done),
        .quotient(quotient), .remainder(remainder),
        .dbz(dbz), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Interpret a W-bit pattern as a signed integer
    function automatic int sx(input int v);
        return (v >= 2**(W-1)) ? v - 2**W : v;
    endfunction

    // Reference: C-style truncating division plus the two special cases
    function automatic void ref_div(input int a, input int b,
                                    output int q, output int r,
                                    output int dz, output int ov);
        dz = 0; ov = 0;
        if (b == 0) begin
            q = -1; r = a; dz = 1;
        end else if (a == -(2**(W-1)) && b == -1) begin
            q = a; r = 0; ov = 1;
        end else begin
            q = a / b; r = a % b;
        end
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    task automatic check_result(input int a, input int b, input string tag);
        int q, r, dz, ov, gq, gr;
        ref_div(a, b, q, r, dz, ov);
        gq = sx(int'(quotient));
        gr = sx(int'(remainder));
        chk({tag, ".q"}, gq, q);
        chk({tag, ".r"}, gr, r);
        chk({tag, ".dbz"}, int'(dbz), dz);
        chk({tag, ".ovf"}, int'(ovf), ov);
        if (dz == 0 && ov == 0) begin
            chk({tag, ".inv"}, gq * b + gr, a);
            chk({tag, ".rmag"}, int'(iabs(gr) < iabs(b)), 1);
            chk({tag, ".rsgn"}, int'(gr == 0 || ((gr < 0) == (a < 0))), 1);
        end
    endtask

    // One isolated operation: start pulse, latency, results, single-cycle done
    task automatic run_op(input int a, input int b, input string tag);
        int edges;
        @(negedge clk);
        start = 1'b1; dividend = W'(a); divisor = W'(b);
        @(negedge clk);
        start = 1'b0;
        edges = 1;
        chk({tag, ".busy"}, int'(busy), 1);
        while (!done && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        chk({tag, ".lat"}, edges, W + 2);
        check_result(a, b, tag);
        @(negedge clk);
        chk({tag, ".pulse"}, int'(done), 0);
    endtask

    initial begin : main
        int edges, cnt;
        int qa[6], qb[6];

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst.busy", int'(busy), 0);
        chk("rst.done", int'(done), 0);
        chk("rst.q", int'(quotient), 0);
        chk("rst.r", int'(remainder), 0);
        chk("rst.dbz", int'(dbz), 0);
        chk("rst.ovf", int'(ovf), 0);
        rst = 1'b0;

        // Directed signed and special cases
        run_op(7, 3, "d7_3");
        run_op(-7, 3, "dm7_3");
        run_op(7, -2, "d7_m2");
        run_op(-6, -3, "dm6_m3");
        run_op(5, 0, "dbz5");
        run_op(-8, -1, "ovf");
        run_op(-8, 1, "m8_1");
        run_op(-8, 0, "dbzm8");

        // Start while busy is ignored
        @(negedge clk);
        start = 1'b1; dividend = W'(6); divisor = W'(2);
        @(negedge clk); start = 1'b0; edges = 1;
        @(negedge clk); edges++;
        start = 1'b1; dividend = W'(7); divisor = W'(1);
        @(negedge clk); edges++; start = 1'b0;
        while (!done && edges < 20) begin
            @(negedge clk);
            edges++;
        end
        chk("ign.lat", edges, W + 2);
        check_result(6, 2, "ign");
        cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("ign.extra_done", cnt, 0);

        // Reset in the middle of CALC aborts the operation
        @(negedge clk);
        start = 1'b1; dividend = W'(7); divisor = W'(3);
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort.busy", int'(busy), 0);
        chk("abort.done", int'(done), 0);
        chk("abort.q", int'(quotient), 0);
        chk("abort.r", int'(remainder), 0);
        @(negedge clk); rst = 1'b0;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (done) cnt++;
        end
        chk("abort.no_done", cnt, 0);
        run_op(4, 2, "post_rst");

        // Held start: back-to-back ops, operands change at each done
        for (int k = 0; k < 6; k++) begin
            qa[k] = sx($urandom_range(0, 15));
            qb[k] = sx($urandom_range(0, 15));
        end
        @(negedge clk);
        start = 1'b1; dividend = W'(qa[0]); divisor = W'(qb[0]);
        for (int k = 0; k < 6; k++) begin
            edges = 0;
            do begin
                @(negedge clk);
                edges++;
            end while (!done && edges < 20);
            chk($sformatf("b2b%0d.gap", k), edges, W + 2);
            check_result(qa[k], qb[k], $sformatf("b2b%0d", k));
            if (k < 5) begin
                dividend = W'(qa[k+1]); divisor = W'(qb[k+1]);
            end else begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        chk("b2b.idle", int'(busy), 0);

        // Random isolated ops
        for (int k = 0; k < 40; k++)
            run_op(sx($urandom_range(0, 15)), sx($urandom_range(0, 15)),
                   $sformatf("rnd%0d", k));

        // Exhaustive operand sweep
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                run_op(sx(i), sx(j), $sformatf("sw%0d_%0d", sx(i), sx(j)));

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
